// File: rtl/mini_uart.sv
// Bus-attached 8N1 UART: one-byte transmitter and receiver with independent
// cycles-per-bit divisors and a sticky line status register.
module mini_uart #(
    parameter logic [15:0] DIV_RESET = 16'd9
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [2:0]  ADD_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    input  logic        RxD,
    output logic        TxD
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

    logic [15:0] divt_q, divt_d, divr_q, divr_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d, ovr_q, ovr_d, fe_q, fe_d;

    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;

    logic        wr_en, rd_en, data_wr, data_rd, lsr_rd, rx_store, tx_idle;
    logic [31:0] lsr;

    assign wr_en   = STB_I & WE_I;
    assign rd_en   = STB_I & ~WE_I;
    assign data_wr = wr_en & (ADD_I == 3'd0);
    assign data_rd = rd_en & (ADD_I == 3'd0);
    assign lsr_rd  = rd_en & (ADD_I == 3'd5);
    assign tx_idle = (tx_state_q == S_IDLE);
    assign lsr     = {26'd0, tx_idle, 2'b00, fe_q, ovr_q, rdy_q};
    assign ACK_O   = STB_I;
    assign TxD     = txd_q;

    always_comb begin
        DAT_O = 32'd0;
        if (rd_en) begin
            case (ADD_I)
                3'd0:    DAT_O = {24'd0, rx_data_q};
                3'd4:    DAT_O = {16'd0, divt_q};
                3'd5:    DAT_O = lsr;
                3'd6:    DAT_O = {16'd0, divr_q};
                default: DAT_O = 32'd0;
            endcase
        end
    end

    always_comb begin
        divt_d = divt_q;
        divr_d = divr_q;
        if (wr_en && ADD_I == 3'd4) divt_d = DAT_I[15:0];
        if (wr_en && ADD_I == 3'd6) divr_d = DAT_I[15:0];
    end

    // Transmitter: the divisor is captured at frame start so bus writes mid-frame cannot stretch it
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        if (tx_state_q == S_IDLE) begin
            if (data_wr) begin
                tx_state_d = S_START;
                tx_div_d   = eff_div(divt_q);
                tx_cnt_d   = eff_div(divt_q) - 16'd1;
                tx_shift_d = DAT_I[7:0];
                tx_bit_d   = 3'd0;
                txd_d      = 1'b0;
            end
        end else if (tx_cnt_q != 16'd0) begin
            tx_cnt_d = tx_cnt_q - 16'd1;
        end else begin
            tx_cnt_d = tx_div_q - 16'd1;
            case (tx_state_q)
                S_START: begin
                    tx_state_d = S_DATA;
                    txd_d      = tx_shift_q[0];
                end
                S_DATA: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
                default: begin
                    tx_state_d = S_IDLE;
                    txd_d      = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        if (rx_state_q == S_IDLE) begin
            if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = S_START;
                rx_div_d   = eff_div(divr_q);
                rx_cnt_d   = (eff_div(divr_q) >> 1) - 16'd1;
            end
        end else if (rx_cnt_q != 16'd0) begin
            rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
            rx_cnt_d = rx_div_q - 16'd1;
            case (rx_state_q)
                S_START: begin
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                    rx_bit_d   = 3'd0;
                end
                S_DATA: begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
                default: rx_state_d = S_IDLE;
            endcase
        end
    end

    // A completing byte outranks any same-cycle read-clear of the status bits
    assign rx_store = (rx_state_q == S_STOP) && (rx_cnt_q == 16'd0);

    always_comb begin
        rx_data_d = rx_store ? rx_shift_q : rx_data_q;
        rdy_d     = rx_store ? 1'b1 : (data_rd ? 1'b0 : rdy_q);
        ovr_d     = (rx_store && rdy_q && !data_rd) ? 1'b1 : (lsr_rd ? 1'b0 : ovr_q);
        fe_d      = rx_store ? ~rx_s2_q : (lsr_rd ? 1'b0 : fe_q);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            divt_q     <= DIV_RESET;
            divr_q     <= DIV_RESET;
            rx_data_q  <= 8'd0;
            rdy_q      <= 1'b0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_div_q   <= 16'd2;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            txd_q      <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_div_q   <= 16'd2;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            divt_q     <= divt_d;
            divr_q     <= divr_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= RxD;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end

endmodule

// File: tb/tb_mini_uart.sv
// Directed bench for mini_uart: register access, TX framing, RX reception and status clearing.
module tb_mini_uart;

    logic        clk, rst, stb, we, ack_o, rxd, txd;
    logic [2:0]  add;
    logic [31:0] dat_i, dat_o;
    int          n_pass, n_total;

    mini_uart #(.DIV_RESET(16'd9)) dut (
        .CLK_I(clk), .RST_I(rst), .ADD_I(add), .DAT_I(dat_i), .DAT_O(dat_o),
        .STB_I(stb), .WE_I(we), .ACK_O(ack_o), .RxD(rxd), .TxD(txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        stb = 1'b1; we = 1'b1; add = a; dat_i = v;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic k);
        @(negedge clk);
        stb = 1'b1; we = 1'b0; add = a;
        #1;
        d = dat_o; k = ack_o;
        @(posedge clk); #1;
        stb = 1'b0;
    endtask

    // Sends one byte and checks TxD at the first and last cycle of every bit slot.
    task automatic tx_frame(input logic [7:0] b, input int div, input int wr_k,
                            input logic [2:0] wa, input logic [31:0] wd, input string nm);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        bus_write(3'd0, {24'd0, b});
        for (int k = 0; k < 10 * div; k++) begin
            if (k == wr_k + 1) begin stb = 1'b0; we = 1'b0; end
            if ((k % div == 0) || (k % div == div - 1)) begin
                n_total++;
                if (txd !== fr[k / div])
                    $display("FAIL %s txd cycle %0d got %b exp %b", nm, k, txd, fr[k / div]);
                else n_pass++;
            end
            if (k == 5 * div + 1) begin
                stb = 1'b1; we = 1'b0; add = 3'd5; #1;
                n_total++;
                if (dat_o !== 32'h00) $display("FAIL %s lsr_busy got %h exp 00", nm, dat_o);
                else n_pass++;
                stb = 1'b0;
            end
            if (k == wr_k) begin stb = 1'b1; we = 1'b1; add = wa; dat_i = wd; end
            @(posedge clk); #1;
        end
        n_total++;
        if (txd !== 1'b1) $display("FAIL %s txd_after got %b exp 1", nm, txd);
        else n_pass++;
        stb = 1'b1; we = 1'b0; add = 3'd5; #1;
        n_total++;
        if (dat_o !== 32'h20) $display("FAIL %s lsr_after got %h exp 20", nm, dat_o);
        else n_pass++;
        stb = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int div);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            repeat (div) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic k;
        rst = 1'b1; stb = 1'b0; we = 1'b0; add = 3'd0; dat_i = 32'd0; rxd = 1'b1;
        #12;
        n_total++;
        if (txd !== 1'b1 || ack_o !== 1'b0 || dat_o !== 32'd0)
            $display("FAIL reset_outputs got txd=%b ack=%b dat=%h exp 1 0 0", txd, ack_o, dat_o);
        else n_pass++;
        rst = 1'b0;
        bus_read(3'd5, d, k);
        n_total++;
        if (d !== 32'h20 || k !== 1'b1) $display("FAIL reset_lsr got %h ack=%b exp 20 ack=1", d, k);
        else n_pass++;
        bus_read(3'd4, d, k);
        n_total++;
        if (d !== 32'd9) $display("FAIL reset_divt got %0d exp 9", d);
        else n_pass++;
        bus_read(3'd6, d, k);
        n_total++;
        if (d !== 32'd9) $display("FAIL reset_divr got %0d exp 9", d);
        else n_pass++;
        bus_read(3'd0, d, k);
        n_total++;
        if (d !== 32'd0) $display("FAIL reset_data got %h exp 0", d);
        else n_pass++;
    endtask

    task automatic test_regs();
        logic [31:0] d; logic k;
        bus_write(3'd1, 32'hDEAD_BEEF);
        bus_read(3'd1, d, k);
        n_total++;
        if (d !== 32'd0) $display("FAIL unused_reg1 got %h exp 0", d);
        else n_pass++;
        bus_read(3'd7, d, k);
        n_total++;
        if (d !== 32'd0) $display("FAIL unused_reg7 got %h exp 0", d);
        else n_pass++;
        @(negedge clk);
        stb = 1'b1; we = 1'b1; add = 3'd5; dat_i = 32'hFF; #1;
        n_total++;
        if (dat_o !== 32'd0 || ack_o !== 1'b1) $display("FAIL write_cycle_dat got %h ack=%b exp 0 ack=1", dat_o, ack_o);
        else n_pass++;
        @(posedge clk); #1; stb = 1'b0; we = 1'b0;
        bus_read(3'd5, d, k);
        n_total++;
        if (d !== 32'h20) $display("FAIL lsr_readonly got %h exp 20", d);
        else n_pass++;
        bus_write(3'd6, 32'h0001_0ABC);
        bus_read(3'd6, d, k);
        n_total++;
        if (d !== 32'h0ABC) $display("FAIL divr_rw got %h exp 0abc", d);
        else n_pass++;
        bus_write(3'd6, 32'd9);
    endtask

    task automatic test_tx();
        tx_frame(8'h12, 9, -1, 3'd0, 32'd0, "tx_12");
    endtask

    task automatic test_tx_busy();
        tx_frame(8'hC3, 9, 20, 3'd0, 32'h55, "tx_busy_write");
    endtask

    task automatic test_divt_midframe();
        logic [31:0] d; logic k;
        tx_frame(8'h3A, 9, 25, 3'd4, 32'd4, "tx_divt_mid");
        bus_read(3'd4, d, k);
        n_total++;
        if (d !== 32'd4) $display("FAIL divt_new got %0d exp 4", d);
        else n_pass++;
        tx_frame(8'h6B, 4, -1, 3'd0, 32'd0, "tx_div4");
    endtask

    task automatic test_div_clamp();
        bus_write(3'd4, 32'd1);
        tx_frame(8'hF0, 2, -1, 3'd0, 32'd0, "tx_div_clamp");
        bus_write(3'd4, 32'd9);
    endtask

    task automatic test_rx();
        logic [31:0] d; logic k;
        bus_write(3'd6, 32'd9);
        send_rx(8'hA5, 1'b1, 9);
        repeat (4) @(posedge clk);
        bus_read(3'd5, d, k);
        n_total++;
        if (d !== 32'h21) $display("FAIL rx_lsr_ready got %h exp 21", d);
        else n_pass++;
        bus_read(3'd0, d, k);
        n_total++;
        if (d !== 32'hA5) $display("FAIL rx_data got %h exp a5", d);
        else n_pass++;
        bus_read(3'd5, d, k);
        n_total++;
        if (d !== 32'h20) $display("FAIL rx_lsr_cleared got %h exp 20", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic k;
        send_rx(8'h3C, 1'b1, 9);
        send_rx(8'h81, 1'b1, 9);
        repeat (4) @(posedge clk);
        bus_read(3'd5, d, k);
        n_total++;
        if (d !== 32'h23) $display("FAIL overrun_lsr got %h exp 23", d);
        else n_pass++;
        bus_read(3'd0, d, k);
        n_total++;
        if (d !== 32'h81) $display("FAIL overrun_data got %h exp 81", d);
        else n_pass++;
        bus_read(3'd5, d, k);
        n_total++;
        if (d !== 32'h20) $display("FAIL overrun_cleared got %h exp 20", d);
        else n_pass++;
    endtask

    task automatic test_framing_glitch();
        logic [31:0] d; logic k;
        send_rx(8'h5A, 1'b0, 9);
        repeat (4) @(posedge clk);
        bus_read(3'd5, d, k);
        n_total++;
        if (d !== 32'h25) $display("FAIL framing_lsr got %h exp 25", d);
        else n_pass++;
        bus_read(3'd0, d, k);
        n_total++;
        if (d !== 32'h5A) $display("FAIL framing_data got %h exp 5a", d);
        else n_pass++;
        bus_read(3'd5, d, k);
        n_total++;
        if (d !== 32'h20) $display("FAIL framing_cleared got %h exp 20", d);
        else n_pass++;
        @(negedge clk); rxd = 1'b0;
        @(negedge clk); rxd = 1'b1;
        repeat (30) @(posedge clk);
        bus_read(3'd5, d, k);
        n_total++;
        if (d !== 32'h20) $display("FAIL glitch_lsr got %h exp 20", d);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d; logic k;
        bus_write(3'd0, 32'h00);
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (txd !== 1'b1) $display("FAIL reset_mid_txd got %b exp 1", txd);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        bus_read(3'd5, d, k);
        n_total++;
        if (d !== 32'h20) $display("FAIL reset_mid_lsr got %h exp 20", d);
        else n_pass++;
        n_total++;
        if (txd !== 1'b1) $display("FAIL reset_mid_idle got %b exp 1", txd);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_regs();
        test_tx();
        test_tx_busy();
        test_divt_midframe();
        test_div_clamp();
        test_rx();
        test_back_to_back();
        test_framing_glitch();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
